// File: rtl/inst_fetch.sv
// Instruction fetch with a one-entry line register in front of a request/ack memory bus.
// A miss stalls the PC while a single outstanding read is tracked; flushed reads drain before reissue.
module inst_fetch #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] program_counter,
  input  logic                  chip_enable,
  input  logic                  branch_flush,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic                  inst_valid,
  output logic                  stall_request,
  output logic                  fetch_error
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  line_valid_q, line_valid_d;
  logic [ADDR_WIDTH-1:0] line_pc_q, line_pc_d;
  logic [DATA_WIDTH-1:0] line_data_q, line_data_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  fetch_error_q, fetch_error_d;

  logic aligned;
  logic hit;
  logic need_fetch;

  assign aligned    = (program_counter[1:0] == 2'b00);
  assign hit        = line_valid_q && (line_pc_q == program_counter) && chip_enable;
  assign need_fetch = chip_enable && aligned && !hit;

  assign instruction   = hit ? line_data_q : '0;
  assign inst_valid    = hit;
  assign stall_request = need_fetch;
  assign mem_req       = mem_req_q;
  assign mem_addr      = mem_addr_q;
  assign fetch_error   = fetch_error_q;

  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    line_valid_d  = line_valid_q;
    line_pc_d     = line_pc_q;
    line_data_d   = line_data_q;
    cnt_d         = cnt_q;
    fetch_error_d = chip_enable && !aligned;

    case (state_q)
      S_IDLE: begin
        // A stray ack here belongs to no request and is ignored.
        if (need_fetch && !branch_flush) begin
          mem_req_d  = 1'b1;
          mem_addr_d = {program_counter[ADDR_WIDTH-1:2], 2'b00};
          cnt_d      = '0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = S_IDLE;
          if (!branch_flush && chip_enable) begin
            line_valid_d = 1'b1;
            line_pc_d    = mem_addr_q;
            line_data_d  = mem_rdata;
          end
        end else if (branch_flush || !chip_enable) begin
          // The bus cannot be aborted, so keep requesting until the ack arrives.
          state_d = S_DRAIN;
        end else if (cnt_q == CNT_LAST) begin
          mem_req_d     = 1'b0;
          fetch_error_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DRAIN: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase

    if (!chip_enable) begin
      line_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      line_valid_q  <= 1'b0;
      line_pc_q     <= '0;
      line_data_q   <= '0;
      cnt_q         <= '0;
      fetch_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      line_valid_q  <= line_valid_d;
      line_pc_q     <= line_pc_d;
      line_data_q   <= line_data_d;
      cnt_q         <= cnt_d;
      fetch_error_q <= fetch_error_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: miss/fill, hold, flush drain, timeout, misalignment, disable, reset.
module tb_inst_fetch;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] program_counter = '0;
  logic        chip_enable = 1'b0;
  logic        branch_flush = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] instruction;
  logic        inst_valid;
  logic        stall_request;
  logic        fetch_error;

  int checks = 0;
  int errors = 0;

  inst_fetch #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
    .clock(clock), .reset(reset), .program_counter(program_counter),
    .chip_enable(chip_enable), .branch_flush(branch_flush),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instruction(instruction), .inst_valid(inst_valid),
    .stall_request(stall_request), .fetch_error(fetch_error)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #2;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset state
    #1 reset = 1'b1;
    #1;
    chk1("rst_req", mem_req, 1'b0);
    chk32("rst_addr", mem_addr, 32'h0);
    chk1("rst_valid", inst_valid, 1'b0);
    chk32("rst_inst", instruction, 32'h0);
    chk1("rst_stall", stall_request, 1'b0);
    chk1("rst_ferr", fetch_error, 1'b0);
    tick();
    reset = 1'b0;

    // miss at 0x100, ack in the third WAIT cycle
    program_counter = 32'h100;
    chip_enable = 1'b1;
    #1;
    chk1("miss_stall_idle", stall_request, 1'b1);
    chk1("miss_req_idle", mem_req, 1'b0);
    tick();
    #1;
    chk1("w1_req", mem_req, 1'b1);
    chk32("w1_addr", mem_addr, 32'h100);
    chk1("w1_stall", stall_request, 1'b1);
    tick();
    #1;
    chk1("w2_req", mem_req, 1'b1);
    chk32("w2_addr", mem_addr, 32'h100);
    tick();
    mem_ack = 1'b1;
    mem_rdata = 32'h1234_5678;
    #1;
    chk1("ack_stall", stall_request, 1'b1);
    chk1("ack_valid", inst_valid, 1'b0);
    chk32("ack_addr", mem_addr, 32'h100);
    tick();
    mem_ack = 1'b0;
    mem_rdata = '0;
    #1;
    chk1("fill_valid", inst_valid, 1'b1);
    chk32("fill_inst", instruction, 32'h1234_5678);
    chk1("fill_stall", stall_request, 1'b0);
    chk1("fill_req", mem_req, 1'b0);

    // PC held: hits every cycle, no new request
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      chk1("hold_req", mem_req, 1'b0);
      chk1("hold_valid", inst_valid, 1'b1);
    end

    // miss at 0x104, flush in second WAIT cycle, late ack is dropped
    program_counter = 32'h104;
    #1;
    chk1("m104_stall", stall_request, 1'b1);
    chk1("m104_valid", inst_valid, 1'b0);
    tick();
    #1;
    chk32("m104_addr", mem_addr, 32'h104);
    tick();
    branch_flush = 1'b1;
    tick();
    branch_flush = 1'b0;
    #1;
    chk1("drain_req", mem_req, 1'b1);
    chk32("drain_addr", mem_addr, 32'h104);
    tick();
    mem_ack = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack = 1'b0;
    mem_rdata = '0;
    #1;
    chk1("drain_done_req", mem_req, 1'b0);
    chk1("drain_done_valid", inst_valid, 1'b0);
    chk1("drain_done_stall", stall_request, 1'b1);
    program_counter = 32'h100;
    #1;
    chk1("line_kept_valid", inst_valid, 1'b1);
    chk32("line_kept_inst", instruction, 32'h1234_5678);
    program_counter = 32'h104;
    tick();
    #1;
    chk1("reissue_req", mem_req, 1'b1);
    chk32("reissue_addr", mem_addr, 32'h104);

    // timeout after four WAIT cycles, then reissue
    tick();
    tick();
    tick();
    #1;
    chk1("to_pre_req", mem_req, 1'b1);
    chk1("to_pre_ferr", fetch_error, 1'b0);
    tick();
    #1;
    chk1("to_req", mem_req, 1'b0);
    chk1("to_ferr", fetch_error, 1'b1);
    chk1("to_stall", stall_request, 1'b1);
    tick();
    #1;
    chk1("to_re_req", mem_req, 1'b1);
    chk1("to_re_ferr", fetch_error, 1'b0);
    chk32("to_re_addr", mem_addr, 32'h104);
    mem_ack = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ack = 1'b0;
    mem_rdata = '0;
    #1;
    chk1("f104_valid", inst_valid, 1'b1);
    chk32("f104_inst", instruction, 32'hCAFE_F00D);

    // misaligned PC
    program_counter = 32'h102;
    #1;
    chk1("mis_req", mem_req, 1'b0);
    chk1("mis_valid", inst_valid, 1'b0);
    chk32("mis_inst", instruction, 32'h0);
    chk1("mis_stall", stall_request, 1'b0);
    tick();
    #1;
    chk1("mis_ferr1", fetch_error, 1'b1);
    chk1("mis_req1", mem_req, 1'b0);
    tick();
    #1;
    chk1("mis_ferr2", fetch_error, 1'b1);
    program_counter = 32'h104;
    #1;
    chk1("mis_back_valid", inst_valid, 1'b1);
    tick();
    #1;
    chk1("mis_ferr_clr", fetch_error, 1'b0);

    // chip_enable low invalidates the line
    chip_enable = 1'b0;
    #1;
    chk1("ce0_valid", inst_valid, 1'b0);
    chk32("ce0_inst", instruction, 32'h0);
    chk1("ce0_stall", stall_request, 1'b0);
    tick();
    #1;
    chk1("ce0_req", mem_req, 1'b0);
    chip_enable = 1'b1;
    #1;
    chk1("ce1_valid", inst_valid, 1'b0);
    chk1("ce1_stall", stall_request, 1'b1);

    // reset asserted between edges mid-WAIT
    tick();
    #1;
    chk1("rw_req", mem_req, 1'b1);
    #3 reset = 1'b1;
    #1;
    chk1("rw_req_async", mem_req, 1'b0);
    chk32("rw_addr_async", mem_addr, 32'h0);
    tick();
    reset = 1'b0;
    program_counter = 32'h0;
    mem_ack = 1'b1;
    mem_rdata = 32'hBAD0_F00D;
    #1;
    chk1("rw_valid_pre", inst_valid, 1'b0);
    tick();
    mem_ack = 1'b0;
    mem_rdata = '0;
    #1;
    chk1("rw_late_ack_valid", inst_valid, 1'b0);
    chk32("rw_late_ack_inst", instruction, 32'h0);
    chk1("rw_newreq", mem_req, 1'b1);
    chk32("rw_newaddr", mem_addr, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter ADDR_WIDTH, 32, byte-address width of program_counter and mem_addr.
REQ-002 Parameter DATA_WIDTH, 32, instruction/memory word width.
REQ-003 Parameter TIMEOUT, 255, max WAIT cycles before a fetch is abandoned; legal range 1..255.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 clock  input  1  sole clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 program_counter  input  ADDR_WIDTH  fetch address from the PC stage.
REQ-008 chip_enable  input  1  fetch enable from the PC stage; 0 = fetch disabled.
REQ-009 branch_flush  input  1  discard any fetch in flight.
REQ-010 mem_req  output  1  memory read request, registered.
REQ-011 mem_addr  output  ADDR_WIDTH  memory word address, registered, bits[1:0] always 0.
REQ-012 mem_ack  input  1  memory read completion strobe, one cycle.
REQ-013 mem_rdata  input  DATA_WIDTH  read data, valid when mem_ack=1.
REQ-014 instruction  output  DATA_WIDTH  fetched word for the decode stage.
REQ-015 inst_valid  output  1  instruction is valid for the current program_counter.
REQ-016 stall_request  output  1  drives stall[0]: hold the PC.
REQ-017 fetch_error  output  1  one-cycle registered pulse: misaligned PC or timeout.

Function
REQ-018 Block SHALL hold one line register: line_valid, line_pc, line_data.
REQ-019 hit SHALL be line_valid && line_pc == program_counter && chip_enable; on hit, instruction=line_data, inst_valid=1, stall_request=0, combinationally in the same cycle.
REQ-020 FSM states SHALL be IDLE, WAIT, DRAIN.
REQ-021 IDLE, chip_enable=1, PC aligned, no hit, branch_flush=0: at the edge, mem_req<=1, mem_addr<=program_counter, cnt<=0, go to WAIT.
REQ-022 stall_request SHALL be 1 whenever chip_enable=1, PC aligned, and no hit, including every WAIT and DRAIN cycle.
REQ-023 mem_req and mem_addr SHALL remain stable from assertion until the edge that samples mem_ack=1.
REQ-024 WAIT, mem_ack=1, branch_flush=0: at the edge, line_valid<=1, line_pc<=mem_addr, line_data<=mem_rdata, mem_req<=0, go to IDLE; the next cycle hits if the PC is unchanged, so miss-to-valid latency is ack cycle + 1.
REQ-025 WAIT, branch_flush=1 without mem_ack: go to DRAIN; mem_req stays 1 because the bus is not aborted.
REQ-026 WAIT or DRAIN, mem_ack=1 with branch_flush=1 or in DRAIN: drop the data, line unchanged, mem_req<=0, go to IDLE.
REQ-027 WAIT: cnt increments each cycle without ack; when cnt==TIMEOUT-1 without ack: mem_req<=0, fetch_error<=1 for one cycle, go to IDLE; the next IDLE cycle re-issues the request.
REQ-028 mem_ack in IDLE SHALL be ignored.
REQ-029 program_counter[1:0]!=0 with chip_enable=1: no request, instruction=0, inst_valid=0, stall_request=0, fetch_error<=1 for one cycle, repeating each cycle the condition holds.
REQ-030 chip_enable=0: instruction=0, inst_valid=0, stall_request=0, no new request, line_valid<=0; any outstanding transaction completes via DRAIN.
REQ-031 Outside hit: instruction=0, inst_valid=0.

Reset
REQ-032 Reset asserted SHALL immediately force state=IDLE, mem_req=0, mem_addr=0, line_valid=0, line_pc=0, line_data=0, cnt=0, fetch_error=0, regardless of clock.
REQ-033 Reset mid-WAIT SHALL abandon the transaction; a late mem_ack after release SHALL be ignored (IDLE).

Verification
REQ-034 PC=0x100, CE=1, ack 3 cycles after mem_req -> mem_addr=0x100 held; stall=1 until the cycle after ack; then instruction=mem_rdata, inst_valid=1, stall=0.
REQ-035 PC held at 0x100 after fill -> no further mem_req; inst_valid=1 every cycle.
REQ-036 Miss at 0x104, branch_flush in 2nd WAIT cycle, ack later with 0xDEADBEEF -> line not updated, state DRAIN then IDLE, new request for the current PC.
REQ-037 PC=0x102, CE=1 -> mem_req=0, inst_valid=0, stall=0, fetch_error=1 each cycle.
REQ-038 TIMEOUT=4, no ack -> fetch_error pulses 1 cycle after 4 WAIT cycles; mem_req drops, then re-asserts the next cycle.
REQ-039 Reset asserted mid-WAIT between clock edges -> mem_req=0 immediately; ack after release ignored; line_valid=0.
